// File: rtl/riscv_mem_access_if.sv
// Data-memory bus between the MEM-stage access unit and data memory.
// The unit holds req until a single-cycle ack pulse arrives. rdata is valid only
// alongside ack.
//   master: drives req/we/addr/wdata, receives ack/rdata (access unit side)
//   slave : receives req/we/addr/wdata, drives ack/rdata (memory side)
interface riscv_mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/riscv_mem_access.sv
// MEM-stage data-memory access unit.
// Turns a load/store from EX/MEM into one req/ack bus transaction. It stalls the
// pipeline until that transaction completes, then presents the writeback
// index/enable/data to MEM/WB for one cycle. Non-memory instructions pass
// straight through combinationally.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset (all outputs forced 0)
//   rd_idx_i/rd_we_i   destination register index / write enable from EX/MEM
//   data_i             ALU result (non-mem) or store data
//   data_we_i/re_i     store / load request (both set = store)
//   data_addr_i        byte address
//   rd_idx_o/rd_we_o   writeback index / enable toward MEM/WB
//   rd_data_o          writeback data toward MEM/WB
//   stallreq_o         stall request to the pipeline controller
//   bus                data-memory bus (master side)
//   err_o              one-cycle pulse when an access is aborted
//
// Optional feature: define MEM_MISALIGN_CHK_EN to reject accesses whose address is
// not word aligned. Such an access skips the bus and goes straight to an aborted DONE.
module riscv_mem_access #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 rd_idx_i,
  input  logic                       rd_we_i,
  input  logic [31:0]                data_i,
  input  logic                       data_we_i,
  input  logic                       data_re_i,
  input  logic [31:0]                data_addr_i,
  output logic [4:0]                 rd_idx_o,
  output logic                       rd_we_o,
  output logic [31:0]                rd_data_o,
  output logic                       stallreq_o,
  riscv_mem_access_if.master         bus,
  output logic                       err_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         rd_idx_q, rd_idx_d;
  logic               rd_we_q, rd_we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               we_q, we_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               abort_q, abort_d;

  logic access;
  assign access = data_re_i | data_we_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rd_idx_q <= '0;
      rd_we_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_idx_q <= rd_idx_d;
      rd_we_q  <= rd_we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_idx_d   = rd_idx_q;
    rd_we_d    = rd_we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    abort_d    = abort_q;
    rd_idx_o   = '0;
    rd_we_o    = 1'b0;
    rd_data_o  = '0;
    stallreq_o = 1'b0;
    err_o      = 1'b0;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;

    case (state_q)
      StIdle: begin
        rd_idx_o  = rd_idx_i;
        rd_we_o   = rd_we_i;
        rd_data_o = data_i;
        if (access) begin
          stallreq_o = 1'b1;
          rd_we_o    = 1'b0;
          rd_idx_d   = rd_idx_i;
          rd_we_d    = rd_we_i;
          addr_d     = data_addr_i;
          data_d     = data_i;
          we_d       = data_we_i;   // store wins when both requests are set
          cnt_d      = '0;
          abort_d    = 1'b0;
          state_d    = StBusy;
`ifdef MEM_MISALIGN_CHK_EN
          if (data_addr_i[1:0] != 2'b00) begin
            abort_d = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end

      StBusy: begin
        stallreq_o = 1'b1;
        rd_idx_o   = rd_idx_q;
        bus.req    = 1'b1;
        bus.we     = we_q;
        bus.addr   = addr_q;
        bus.wdata  = data_q;
        // An ack on the final allowed cycle still completes normally.
        if (bus.ack) begin
          rdata_d = bus.rdata;
          state_d = StDone;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        // EX/MEM still holds the finished instruction here, so its request is ignored.
        rd_idx_o  = rd_idx_q;
        rd_data_o = we_q ? data_q : rdata_q;
        rd_we_o   = rd_we_q & ~we_q & ~abort_q;
        err_o     = abort_q;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Outputs are forced low for the whole reset, pass-through paths included.
    if (rst) begin
      rd_idx_o   = '0;
      rd_we_o    = 1'b0;
      rd_data_o  = '0;
      stallreq_o = 1'b0;
      err_o      = 1'b0;
      bus.req    = 1'b0;
      bus.we     = 1'b0;
      bus.addr   = '0;
      bus.wdata  = '0;
    end
  end

endmodule
